seeed_tft_pixel_feeder: RTL and testbench
=========================================

# seeed_tft_pixel_feeder

Upstream stage of the Seeed TFT data writer. Accepts a valid/ready stream of RGB565 or RGB888 pixels and expands each pixel to the 32-bit {R,G,B,8'h00} word the writer consumes. Fills the write side of the writer's ping-pong FIFO one buffer at a time, and commits partial buffers at end of frame. Frame length is taken from the same pixel count the writer uses.

## Interface
Parameters:
- FIFO_SIZE_WIDTH, 24, width of the FIFO size bus.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_enable  in  1  run enable; low aborts the current frame.
- i_num_pixels  in  32  pixels per frame; sampled at frame start.
- i_pixel_format  in  1  0 = RGB565 in i_pix_data[15:0]; 1 = RGB888 in i_pix_data[23:0].
- i_pix_valid  in  1  upstream pixel valid.
- o_pix_ready  out  1  feeder accepts the pixel this cycle.
- i_pix_data  in  24  pixel data.
- i_fifo_rdy  in  2  ping-pong write buffers available.
- o_fifo_act  out  2  buffer ownership, one-hot or zero.
- o_fifo_stb  out  1  write strobe.
- i_fifo_size  in  FIFO_SIZE_WIDTH  capacity of the granted buffer, in words.
- o_fifo_data  out  32  expanded pixel word.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse after the last pixel of a frame is committed.

## Operation
- States: IDLE, GET_BUFFER, FILL, RELEASE.
- IDLE:
  - Holds o_fifo_act = 0 and o_pix_ready = 0.
  - If i_enable is high and i_num_pixels != 0: latches frame length, clears pixel count, sets o_busy, goes to GET_BUFFER.
- GET_BUFFER:
  - Waits for i_fifo_rdy != 0 with o_fifo_act == 0.
  - Grants bit 0 when rdy[0] is set, otherwise bit 1.
  - Clears word count and goes to FILL.
- FILL:
  - o_pix_ready = 1 when word_count < i_fifo_size and pixel_count < frame length. It is decoded from registered state only, never from i_pix_valid.
  - On each accept (valid & ready): registers the expanded word into o_fifo_data, pulses o_fifo_stb the next cycle, and increments word_count and pixel_count.
  - An accept that fills the buffer (word_count+1 == i_fifo_size) or ends the frame (pixel_count+1 == frame length) moves the block to RELEASE.
- RELEASE:
  - Clears o_fifo_act.
  - If the frame is complete: pulses o_frame_done, clears o_busy, goes to IDLE.
  - Otherwise goes to GET_BUFFER.
- Expansion, RGB565: R = {d[15:11],d[15:13]}, G = {d[10:5],d[10:9]}, B = {d[4:0],d[4:2]}.
- Expansion, RGB888: R = d[23:16], G = d[15:8], B = d[7:0].
- Word = {R,G,B,8'h00}.
- Counters: pixel_count is 32-bit; word_count is FIFO_SIZE_WIDTH. Comparisons are unsigned. No counter wraps, because the frame terminates at the latched length.
- i_enable low in any non-IDLE state:
  - Next edge: o_fifo_act cleared, which commits any partially filled buffer.
  - Any strobe already registered is still issued that cycle.
  - Counters cleared, state returns to IDLE, no o_frame_done pulse.
- Changes to i_pixel_format mid-frame take effect on the next accepted pixel. Changes to i_num_pixels mid-frame are ignored.

## Timing
- Reset values: o_fifo_act = 0, o_fifo_stb = 0, o_fifo_data = 0, o_pix_ready = 0, o_busy = 0, o_frame_done = 0, state = IDLE.
- Reset assertion takes effect immediately. Deassertion is synchronous to clk.
- Latency: pixel accepted at edge N produces o_fifo_stb and o_fifo_data valid in the cycle after N, sampled by the FIFO at edge N+1.
- Throughput: one pixel per clock while in FILL.
- Buffer turnaround costs 2 cycles (RELEASE, GET_BUFFER) when the other buffer is already ready.
- Final strobe of a buffer: o_fifo_act stays high through the edge that samples it, and drops in the following cycle.
- o_fifo_act changes only in GET_BUFFER (grant) and RELEASE/abort (clear). It never switches directly between bits.
- Both i_fifo_rdy bits set in GET_BUFFER: bit 0 wins.

## Structure
- seeed_tft_defines.v holds the shared definitions:
  - feeder state encodings (IDLE=0, GET_BUFFER=1, FILL=2, RELEASE=3);
  - pixel-format codes (`PIX_FMT_RGB565 = 0`, `PIX_FMT_RGB888 = 1`).
- One combinational sub-module, seeed_tft_pixel_expand: in i_pix_data and i_pixel_format, out the 32-bit word.
- The feeder instantiates it once ahead of the o_fifo_data register.

## Test plan
- RGB565 conversion: num_pixels=4, fifo_size=8, RGB565 pixels 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF → words 32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'hFFFFFF00. o_fifo_act[0] drops one cycle after the 4th strobe; o_frame_done pulses once.
- Buffer alternation: num_pixels=10, fifo_size=4, both buffers ready → strobes in groups 4/4/2 on act[0], act[1], act[0]; 10 strobes total; one o_frame_done.
- Backpressure: fifo_size=4, i_fifo_rdy=0 after the first buffer → o_pix_ready stays 0 and no strobes occur until rdy returns, then filling resumes with no lost or duplicated pixel.
- Upstream bubbles: i_pix_valid toggled every other cycle, RGB888, 6 pixels → exactly 6 strobes, each with data equal to {pixel,8'h00}, in order.
- Abort: i_enable dropped after 3 of 8 pixels → act clears next edge, 3 strobes committed, no o_frame_done, state IDLE. Re-enable starts a new frame from pixel 0.
- Reset mid-FILL: rst_n low → all outputs at reset values in the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/seeed_tft_pixel_feeder_pkg.sv
// Shared types and codes for the Seeed TFT pixel feeder.
// Feeder state encoding, pixel-format codes and word packing.
package seeed_tft_pixel_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GET_BUFFER = 2'd1,
    FILL       = 2'd2,
    RELEASE    = 2'd3
  } feeder_state_t;

  localparam logic PIX_FMT_RGB565 = 1'b0;
  localparam logic PIX_FMT_RGB888 = 1'b1;

  function automatic logic [31:0] pack_word(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b
  );
    return {r, g, b, 8'h00};
  endfunction

endpackage

// File: rtl/seeed_tft_pixel_feeder_if.sv
// Pixel stream and ping-pong FIFO write bus of the feeder.
// master = feeder side, slave = source/FIFO side.
interface seeed_tft_pixel_feeder_if #(
  parameter int FIFO_SIZE_WIDTH = 24
);
  logic                       i_pix_valid;
  logic                       o_pix_ready;
  logic [23:0]                i_pix_data;
  logic [1:0]                 i_fifo_rdy;
  logic [1:0]                 o_fifo_act;
  logic                       o_fifo_stb;
  logic [FIFO_SIZE_WIDTH-1:0] i_fifo_size;
  logic [31:0]                o_fifo_data;

  modport master (
    input  i_pix_valid,
    input  i_pix_data,
    input  i_fifo_rdy,
    input  i_fifo_size,
    output o_pix_ready,
    output o_fifo_act,
    output o_fifo_stb,
    output o_fifo_data
  );

  modport slave (
    output i_pix_valid,
    output i_pix_data,
    output i_fifo_rdy,
    output i_fifo_size,
    input  o_pix_ready,
    input  o_fifo_act,
    input  o_fifo_stb,
    input  o_fifo_data
  );

endinterface

// File: rtl/seeed_tft_pixel_expand.sv
// Expands an RGB565 or RGB888 pixel to the {R,G,B,8'h00} word.
// RGB565 channels replicate their MSBs to fill 8 bits.
module seeed_tft_pixel_expand
  import seeed_tft_pixel_feeder_pkg::*;
(
  input  logic [23:0] i_pix_data,
  input  logic        i_pixel_format,
  output logic [31:0] o_word
);

  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  // channel select by pixel format
  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    unique case (1'b1)
      (i_pixel_format == PIX_FMT_RGB888): begin
        r = i_pix_data[23:16];
        g = i_pix_data[15:8];
        b = i_pix_data[7:0];
      end
      default: begin
        r = {i_pix_data[15:11], i_pix_data[15:13]};
        g = {i_pix_data[10:5], i_pix_data[10:9]};
        b = {i_pix_data[4:0], i_pix_data[4:2]};
      end
    endcase
  end

  assign o_word = pack_word(r, g, b);

endmodule

// File: rtl/seeed_tft_pixel_feeder.sv
// Feeds expanded pixels into the writer's ping-pong FIFO.
// One buffer at a time; partial buffers committed at frame end.
module seeed_tft_pixel_feeder
  import seeed_tft_pixel_feeder_pkg::*;
#(
  parameter int FIFO_SIZE_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_enable,
  input  logic [31:0]              i_num_pixels,
  input  logic                     i_pixel_format,
  seeed_tft_pixel_feeder_if.master bus,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam logic [FIFO_SIZE_WIDTH-1:0] WC_ONE = 1;

  feeder_state_t state;
  feeder_state_t state_nxt;

  logic [31:0]                frame_len;
  logic [31:0]                pix_cnt;
  logic [FIFO_SIZE_WIDTH-1:0] word_cnt;
  logic [1:0]                 act;
  logic                       stb;
  logic [31:0]                data;
  logic                       busy;
  logic                       done;
  logic [31:0]                word;
  logic                       pix_ready;
  logic                       accept;
  logic                       buf_full;
  logic                       frame_end;
  logic                       frame_cmp;
  logic                       start;
  logic                       grant;

  seeed_tft_pixel_expand u_expand (
    .i_pix_data     (bus.i_pix_data),
    .i_pixel_format (i_pixel_format),
    .o_word         (word)
  );

  assign pix_ready = (state == FILL)
                  && (word_cnt < bus.i_fifo_size)
                  && (pix_cnt < frame_len);
  assign accept    = pix_ready & bus.i_pix_valid;
  assign buf_full  = (word_cnt + WC_ONE) == bus.i_fifo_size;
  assign frame_end = (pix_cnt + 32'd1) == frame_len;
  assign frame_cmp = pix_cnt == frame_len;
  assign start     = i_enable && (i_num_pixels != 32'd0);
  assign grant     = (bus.i_fifo_rdy != 2'b00) && (act == 2'b00);

  // next-state decode; enable low always returns to IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = GET_BUFFER;
      GET_BUFFER: if (grant) state_nxt = FILL;
      FILL: begin
        if (accept && (buf_full || frame_end))
          state_nxt = RELEASE;
      end
      RELEASE:    state_nxt = frame_cmp ? IDLE : GET_BUFFER;
      default:    state_nxt = IDLE;
    endcase
    if (!i_enable) state_nxt = IDLE;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // counters, buffer ownership and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_len <= '0;
      pix_cnt   <= '0;
      word_cnt  <= '0;
      act       <= '0;
      stb       <= 1'b0;
      data      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      stb  <= 1'b0;
      done <= 1'b0;
      if (!i_enable && state != IDLE) begin
        act      <= '0;
        pix_cnt  <= '0;
        word_cnt <= '0;
        busy     <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              frame_len <= i_num_pixels;
              pix_cnt   <= '0;
              busy      <= 1'b1;
            end
          end
          GET_BUFFER: begin
            if (grant) begin
              act      <= bus.i_fifo_rdy[0] ? 2'b01 : 2'b10;
              word_cnt <= '0;
            end
          end
          FILL: begin
            if (accept) begin
              data     <= word;
              stb      <= 1'b1;
              word_cnt <= word_cnt + WC_ONE;
              pix_cnt  <= pix_cnt + 32'd1;
            end
          end
          RELEASE: begin
            act <= '0;
            if (frame_cmp) begin
              done <= 1'b1;
              busy <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_pix_ready = pix_ready;
  assign bus.o_fifo_act  = act;
  assign bus.o_fifo_stb  = stb;
  assign bus.o_fifo_data = data;
  assign o_busy          = busy;
  assign o_frame_done    = done;

endmodule

// File: tb/tb_seeed_tft_pixel_feeder.sv
// Self-checking bench for seeed_tft_pixel_feeder.
// Random pixels against a word/buffer model from the frame rules.
module tb_seeed_tft_pixel_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] num = '0;
  logic        fmt = 1'b0;
  logic        busy;
  logic        done;
  logic        hold = 1'b0;
  logic        stop_drv = 1'b0;
  logic [1:0]  rdy_st = 2'b11;
  logic [1:0]  prev_act = 2'b00;
  int          rdy_req = 0;
  int          rdy_seen = 0;

  int total = 0;
  int bad = 0;

  logic [31:0] mon_d[$];
  logic [1:0]  mon_a[$];
  logic        hist_stb[$];
  logic [1:0]  hist_act[$];
  int          done_cnt = 0;
  int          act_err = 0;

  logic [23:0] pix[$];
  logic        pfmt[$];

  seeed_tft_pixel_feeder_if #(.FIFO_SIZE_WIDTH(24)) bus ();

  seeed_tft_pixel_feeder #(.FIFO_SIZE_WIDTH(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_enable       (en),
    .i_num_pixels   (num),
    .i_pixel_format (fmt),
    .bus            (bus),
    .o_busy         (busy),
    .o_frame_done   (done)
  );

  always #5 clk = ~clk;

  assign bus.i_fifo_rdy = hold ? 2'b00 : rdy_st;

  // output monitor plus ping-pong FIFO model: a released buffer
  // goes busy draining while the other one becomes free
  always @(negedge clk) begin
    if (bus.o_fifo_stb) begin
      mon_d.push_back(bus.o_fifo_data);
      mon_a.push_back(bus.o_fifo_act);
    end
    hist_stb.push_back(bus.o_fifo_stb);
    hist_act.push_back(bus.o_fifo_act);
    if (done) done_cnt++;
    if (bus.o_fifo_act == 2'b11) act_err++;
    if (prev_act != 2'b00 && bus.o_fifo_act != 2'b00
        && bus.o_fifo_act != prev_act) act_err++;
    if (prev_act[0] && !bus.o_fifo_act[0]) rdy_st = 2'b10;
    if (prev_act[1] && !bus.o_fifo_act[1]) rdy_st = 2'b01;
    if (rdy_req != rdy_seen) begin
      rdy_st = 2'b11;
      rdy_seen = rdy_req;
    end
    prev_act = bus.o_fifo_act;
  end

  function automatic logic [31:0] exp_word(input logic [23:0] d,
                                           input logic f);
    int v, r, g, b, r5, g6, b5;
    v = int'(d);
    if (f) begin
      r = (v >> 16) & 255;
      g = (v >> 8) & 255;
      b = v & 255;
    end else begin
      r5 = (v >> 11) & 31;
      g6 = (v >> 5) & 63;
      b5 = v & 31;
      r = r5 * 8 + r5 / 4;
      g = g6 * 4 + g6 / 16;
      b = b5 * 8 + b5 / 4;
    end
    return (32'(r) << 24) | (32'(g) << 16) | (32'(b) << 8);
  endfunction

  function automatic logic [1:0] exp_act(input int i, input int s);
    return (((i / s) % 2) == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic new_frame(input int n, input int f, input int sz);
    pix.delete();
    pfmt.delete();
    for (int i = 0; i < n; i++) begin
      pix.push_back(24'($urandom));
      pfmt.push_back((f < 0) ? 1'($urandom_range(0, 1)) : 1'(f));
    end
    bus.i_fifo_size = 24'(sz);
    rdy_req++;
    tick();
  endtask

  task automatic drive_frame(input int bub, input int stop_after,
                             output bit to);
    int idx;
    int cyc;
    bit v;
    bit acc;
    idx = 0;
    cyc = 0;
    to = 0;
    num = 32'(pix.size());
    en = 1'b1;
    while (idx < pix.size() && !stop_drv) begin
      if (stop_after >= 0 && idx == stop_after) begin
        en = 1'b0;
        break;
      end
      if (cyc > 3000) begin
        to = 1;
        break;
      end
      v = (bub == 0) ? 1'b1 :
          (bub == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
      bus.i_pix_valid = v;
      bus.i_pix_data  = pix[idx];
      fmt             = pfmt[idx];
      acc = v && bus.o_pix_ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    bus.i_pix_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit to);
    int c;
    c = 0;
    while (busy && c < 500) begin
      tick();
      c++;
    end
    to = busy;
    en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_pix_valid = 1'b0;
    bus.i_pix_data  = '0;
    bus.i_fifo_size = 24'd8;
    #1;
    total++;
    if ({bus.o_fifo_act, bus.o_fifo_stb, bus.o_fifo_data,
         bus.o_pix_ready, busy, done} !== 39'd0) begin
      bad++;
      $display("FAIL reset_values act=%b stb=%b data=%h rdy=%b busy=%b done=%b want all 0",
               bus.o_fifo_act, bus.o_fifo_stb, bus.o_fifo_data,
               bus.o_pix_ready, busy, done);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rgb565();
    int db, mb, hb, j, s;
    bit to, t2;
    logic [23:0] p[4];
    p = '{24'h00F800, 24'h0007E0, 24'h00001F, 24'h00FFFF};
    new_frame(4, 0, 8);
    for (int i = 0; i < 4; i++) pix[i] = p[i];
    db = done_cnt;
    mb = mon_d.size();
    hb = hist_stb.size();
    drive_frame(0, -1, to);
    wait_idle(t2);
    total++;
    if (to || t2 || mon_d.size() - mb != 4) begin
      bad++;
      $display("FAIL rgb565_count got=%0d want=4 timeout=%0b",
               mon_d.size() - mb, to | t2);
    end
    for (int i = 0; i < 4 && mb + i < mon_d.size(); i++) begin
      total++;
      if (mon_d[mb+i] !== exp_word(pix[i], 1'b0)
          || mon_a[mb+i] !== 2'b01) begin
        bad++;
        $display("FAIL rgb565_word%0d got=%h/%b want=%h/01", i,
                 mon_d[mb+i], mon_a[mb+i], exp_word(pix[i], 1'b0));
      end
    end
    j = -1;
    s = 0;
    for (int k = hb; k < hist_stb.size(); k++) begin
      if (hist_stb[k]) s++;
      if (s == 4 && j < 0) j = k;
    end
    total++;
    if (j < 0 || j + 1 >= hist_act.size()
        || hist_act[j] !== 2'b01 || hist_act[j+1] !== 2'b00) begin
      bad++;
      $display("FAIL rgb565_act_drop idx=%0d want act 01 then 00", j);
    end
    total++;
    if (done_cnt - db != 1) begin
      bad++;
      $display("FAIL rgb565_done got=%0d want=1", done_cnt - db);
    end
  endtask

  task automatic test_alternation();
    int db, mb;
    bit to, t2;
    new_frame(10, 1, 4);
    db = done_cnt;
    mb = mon_d.size();
    drive_frame(0, -1, to);
    wait_idle(t2);
    total++;
    if (to || t2 || mon_d.size() - mb != 10) begin
      bad++;
      $display("FAIL alt_count got=%0d want=10", mon_d.size() - mb);
    end
    for (int i = 0; i < 10 && mb + i < mon_d.size(); i++) begin
      total++;
      if (mon_d[mb+i] !== exp_word(pix[i], pfmt[i])
          || mon_a[mb+i] !== exp_act(i, 4)) begin
        bad++;
        $display("FAIL alt_word%0d got=%h/%b want=%h/%b", i,
                 mon_d[mb+i], mon_a[mb+i],
                 exp_word(pix[i], pfmt[i]), exp_act(i, 4));
      end
    end
    total++;
    if (done_cnt - db != 1) begin
      bad++;
      $display("FAIL alt_done got=%0d want=1", done_cnt - db);
    end
  endtask

  task automatic test_backpressure();
    int db, mb, c, rdy_hi, extra;
    bit to, t2;
    new_frame(8, 0, 4);
    db = done_cnt;
    mb = mon_d.size();
    rdy_hi = 0;
    extra = 0;
    fork
      drive_frame(0, -1, to);
      begin
        c = 0;
        while (mon_d.size() < mb + 4 && c < 500) begin
          tick();
          c++;
        end
        hold = 1'b1;
        repeat (20) begin
          tick();
          if (bus.o_pix_ready) rdy_hi++;
          if (bus.o_fifo_stb) extra++;
        end
        hold = 1'b0;
      end
    join
    wait_idle(t2);
    total++;
    if (rdy_hi != 0 || extra != 0) begin
      bad++;
      $display("FAIL bp_stall ready_cycles=%0d strobes=%0d want 0/0",
               rdy_hi, extra);
    end
    total++;
    if (to || t2 || mon_d.size() - mb != 8) begin
      bad++;
      $display("FAIL bp_count got=%0d want=8", mon_d.size() - mb);
    end
    for (int i = 0; i < 8 && mb + i < mon_d.size(); i++) begin
      total++;
      if (mon_d[mb+i] !== exp_word(pix[i], 1'b0)
          || mon_a[mb+i] !== exp_act(i, 4)) begin
        bad++;
        $display("FAIL bp_word%0d got=%h/%b want=%h/%b", i,
                 mon_d[mb+i], mon_a[mb+i],
                 exp_word(pix[i], 1'b0), exp_act(i, 4));
      end
    end
    total++;
    if (done_cnt - db != 1) begin
      bad++;
      $display("FAIL bp_done got=%0d want=1", done_cnt - db);
    end
  endtask

  task automatic test_bubbles();
    int mb;
    bit to, t2;
    new_frame(6, 1, 8);
    mb = mon_d.size();
    drive_frame(1, -1, to);
    wait_idle(t2);
    total++;
    if (to || t2 || mon_d.size() - mb != 6) begin
      bad++;
      $display("FAIL bub_count got=%0d want=6", mon_d.size() - mb);
    end
    for (int i = 0; i < 6 && mb + i < mon_d.size(); i++) begin
      total++;
      if (mon_d[mb+i] !== {pix[i], 8'h00}) begin
        bad++;
        $display("FAIL bub_word%0d got=%h want=%h", i,
                 mon_d[mb+i], {pix[i], 8'h00});
      end
    end
  endtask

  task automatic test_abort();
    int db, mb;
    bit to, t2;
    new_frame(8, 1, 8);
    db = done_cnt;
    mb = mon_d.size();
    drive_frame(0, 3, to);
    tick();
    total++;
    if (bus.o_fifo_act !== 2'b00 || busy !== 1'b0
        || bus.o_pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle act=%b busy=%b rdy=%b want 00/0/0",
               bus.o_fifo_act, busy, bus.o_pix_ready);
    end
    repeat (3) tick();
    total++;
    if (to || mon_d.size() - mb != 3 || done_cnt != db) begin
      bad++;
      $display("FAIL abort_commit strobes=%0d done=%0d want 3/0",
               mon_d.size() - mb, done_cnt - db);
    end
    for (int i = 0; i < 3 && mb + i < mon_d.size(); i++) begin
      total++;
      if (mon_d[mb+i] !== exp_word(pix[i], 1'b1)
          || mon_a[mb+i] !== 2'b01) begin
        bad++;
        $display("FAIL abort_word%0d got=%h/%b want=%h/01", i,
                 mon_d[mb+i], mon_a[mb+i], exp_word(pix[i], 1'b1));
      end
    end
    new_frame(3, 1, 8);
    db = done_cnt;
    mb = mon_d.size();
    drive_frame(0, -1, to);
    wait_idle(t2);
    total++;
    if (to || t2 || mon_d.size() - mb != 3 || done_cnt - db != 1) begin
      bad++;
      $display("FAIL restart_count strobes=%0d done=%0d want 3/1",
               mon_d.size() - mb, done_cnt - db);
    end
    for (int i = 0; i < 3 && mb + i < mon_d.size(); i++) begin
      total++;
      if (mon_d[mb+i] !== exp_word(pix[i], 1'b1)) begin
        bad++;
        $display("FAIL restart_word%0d got=%h want=%h", i,
                 mon_d[mb+i], exp_word(pix[i], 1'b1));
      end
    end
  endtask

  task automatic test_random();
    int db, mb, n, sz, errs;
    bit to, t2;
    for (int f = 0; f < 4; f++) begin
      n  = $urandom_range(1, 14);
      sz = $urandom_range(1, 5);
      new_frame(n, -1, sz);
      db = done_cnt;
      mb = mon_d.size();
      drive_frame(2, -1, to);
      wait_idle(t2);
      errs = 0;
      for (int i = 0; i < n && mb + i < mon_d.size(); i++)
        if (mon_d[mb+i] !== exp_word(pix[i], pfmt[i])
            || mon_a[mb+i] !== exp_act(i, sz)) errs++;
      total++;
      if (to || t2 || mon_d.size() - mb != n
          || done_cnt - db != 1 || errs != 0) begin
        bad++;
        $display("FAIL rand%0d n=%0d size=%0d strobes=%0d done=%0d word_errs=%0d",
                 f, n, sz, mon_d.size() - mb, done_cnt - db, errs);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int mb, c;
    bit to;
    new_frame(20, 0, 8);
    mb = mon_d.size();
    fork
      drive_frame(0, -1, to);
      begin
        c = 0;
        while (mon_d.size() < mb + 3 && c < 500) begin
          tick();
          c++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.o_fifo_act, bus.o_fifo_stb, bus.o_fifo_data,
             bus.o_pix_ready, busy, done} !== 39'd0) begin
          bad++;
          $display("FAIL reset_mid_fill act=%b stb=%b data=%h rdy=%b busy=%b want all 0",
                   bus.o_fifo_act, bus.o_fifo_stb, bus.o_fifo_data,
                   bus.o_pix_ready, busy);
        end
        stop_drv = 1'b1;
      end
    join
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stop_drv = 1'b0;
    tick();
  endtask

  task automatic test_act_integrity();
    total++;
    if (act_err != 0) begin
      bad++;
      $display("FAIL act_onehot_switch events=%0d want=0", act_err);
    end
  endtask

  initial begin
    test_reset();
    test_rgb565();
    test_alternation();
    test_backpressure();
    test_bubbles();
    test_abort();
    test_random();
    test_reset_mid_fill();
    test_act_integrity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
